// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage front end for a word-only data RAM.
// Sub-word loads are extracted here; sub-word stores become a 2-cycle read-modify-write with a stall.
`default_nettype none

module load_store_unit #(
    parameter int RAM_SIZE_BIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        addr_err,
    output logic [7:0]  err_count,
    output logic        dm_read,
    output logic        dm_write,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_t;

    localparam logic [32:0] ADDR_LIMIT = 33'd4 << RAM_SIZE_BIT;

    state_t      state_q, state_d;
    logic [31:0] merge_q, merge_d;
    logic [7:0]  err_count_q, err_count_d;

    logic        w_req, w_byte, w_half, w_word, w_misalign, w_range;
    logic [7:0]  w_byte_val;
    logic [15:0] w_half_val;
    logic [31:0] w_load, w_merge;

    assign w_req      = mem_read | mem_write;
    assign w_byte     = (mem_size == 2'b00);
    assign w_half     = (mem_size == 2'b01);
    assign w_word     = mem_size[1];
    assign w_misalign = (w_half & addr[0]) | (w_word & (addr[1:0] != 2'b00));
    assign w_range    = ({1'b0, addr} >= ADDR_LIMIT);
    assign addr_err   = ~reset & (w_misalign | w_range);
    assign dm_addr    = {addr[31:2], 2'b00};
    assign err_count  = err_count_q;

    always_comb begin
        w_byte_val = dm_rdata[{addr[1:0], 3'b000} +: 8];
        w_half_val = addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        if (w_byte)
            w_load = {{24{w_byte_val[7] & ~mem_unsigned}}, w_byte_val};
        else if (w_half)
            w_load = {{16{w_half_val[15] & ~mem_unsigned}}, w_half_val};
        else
            w_load = dm_rdata;
    end

    // Merged word for the RMW: memory contents with only the target lane replaced.
    always_comb begin
        w_merge = dm_rdata;
        if (w_byte)
            w_merge[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
        else if (addr[1])
            w_merge[31:16] = wdata[15:0];
        else
            w_merge[15:0] = wdata[15:0];
    end

    always_comb begin
        state_d   = state_q;
        merge_d   = merge_q;
        dm_read   = 1'b0;
        dm_write  = 1'b0;
        stall     = 1'b0;
        load_data = 32'h0;
        dm_wdata  = wdata;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (w_req && !addr_err) begin
                        if (mem_write) begin
                            if (w_word) begin
                                dm_write = 1'b1;
                            end else begin
                                dm_read = 1'b1;
                                stall   = 1'b1;
                                merge_d = w_merge;
                                state_d = RMW_WR;
                            end
                        end else begin
                            dm_read   = 1'b1;
                            load_data = w_load;
                        end
                    end
                end
                RMW_WR: begin
                    dm_write = 1'b1;
                    dm_wdata = merge_q;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        err_count_d = err_count_q;
        if (addr_err && w_req && (err_count_q != 8'hFF))
            err_count_d = err_count_q + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            merge_q     <= 32'h0;
            err_count_q <= 8'h0;
        end else begin
            state_q     <= state_d;
            merge_q     <= merge_d;
            err_count_q <= err_count_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word-addressed memory model.
`default_nettype none

module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write, mem_unsigned;
    logic [1:0]  mem_size;
    logic [31:0] addr, wdata;
    logic [31:0] load_data, dm_addr, dm_wdata, dm_rdata;
    logic        stall, addr_err, dm_read, dm_write;
    logic [7:0]  err_count;

    logic [31:0] mem [0:255];
    int checks = 0;
    int errors = 0;

    load_store_unit #(.RAM_SIZE_BIT(8)) dut (
        .clk(clk), .reset(reset),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned),
        .addr(addr), .wdata(wdata),
        .load_data(load_data), .stall(stall), .addr_err(addr_err),
        .err_count(err_count),
        .dm_read(dm_read), .dm_write(dm_write),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    assign dm_rdata = mem[dm_addr[9:2]];
    always @(posedge clk) if (dm_write) mem[dm_addr[9:2]] <= dm_wdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] wd);
        mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = uns;
        addr = a; wdata = wd;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        reset = 1'b1;
        drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        step();
        check("rst_stall", {31'h0, stall}, 32'h0);
        check("rst_errcnt", {24'h0, err_count}, 32'h0);
        check("rst_dmread", {31'h0, dm_read}, 32'h0);
        reset = 1'b0;
        step();

        // word store then word load
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678);
        check("sw_dmwrite", {31'h0, dm_write}, 32'h1);
        check("sw_stall", {31'h0, stall}, 32'h0);
        check("sw_wdata", dm_wdata, 32'h12345678);
        step();
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        check("lw_dmwrite", {31'h0, dm_write}, 32'h0);
        check("lw_dmread", {31'h0, dm_read}, 32'h1);
        check("lw_data", load_data, 32'h12345678);
        step();

        // sign/zero extended sub-word loads
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF7F01);
        step();
        drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        check("lb_13", load_data, 32'hFFFFFF80);
        drive(1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        check("lbu_13", load_data, 32'h00000080);
        drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
        check("lb_11", load_data, 32'h0000007F);
        drive(1'b1, 1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
        check("lbu_10", load_data, 32'h00000001);
        drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        check("lh_12", load_data, 32'hFFFF80FF);
        drive(1'b1, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
        check("lhu_12", load_data, 32'h000080FF);
        drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
        check("lh_10", load_data, 32'h00007F01);
        drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        check("idle_data", load_data, 32'h0);
        check("idle_dmread", {31'h0, dm_read}, 32'h0);
        step();

        // byte store RMW
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h14, 32'hAABBCCDD);
        step();
        drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h15, 32'h000000EE);
        check("sb_c1_stall", {31'h0, stall}, 32'h1);
        check("sb_c1_dmread", {31'h0, dm_read}, 32'h1);
        check("sb_c1_dmwrite", {31'h0, dm_write}, 32'h0);
        check("sb_c1_dmaddr", dm_addr, 32'h14);
        step();
        check("sb_c2_dmwrite", {31'h0, dm_write}, 32'h1);
        check("sb_c2_dmread", {31'h0, dm_read}, 32'h0);
        check("sb_c2_wdata", dm_wdata, 32'hAABBEEDD);
        check("sb_c2_stall", {31'h0, stall}, 32'h0);
        step();
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
        check("sb_readback", load_data, 32'hAABBEEDD);
        step();

        // halfword store RMW
        drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h16, 32'h00001234);
        check("sh_c1_stall", {31'h0, stall}, 32'h1);
        check("sh_c1_dmread", {31'h0, dm_read}, 32'h1);
        step();
        check("sh_c2_dmwrite", {31'h0, dm_write}, 32'h1);
        check("sh_c2_wdata", dm_wdata, 32'h1234EEDD);
        check("sh_c2_stall", {31'h0, stall}, 32'h0);
        step();
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
        check("sh_readback", load_data, 32'h1234EEDD);
        step();

        // faulting accesses
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h11, 32'h0);
        check("lw11_err", {31'h0, addr_err}, 32'h1);
        check("lw11_dmread", {31'h0, dm_read}, 32'h0);
        check("lw11_data", load_data, 32'h0);
        step();
        check("errcnt_1", {24'h0, err_count}, 32'h1);
        drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h13, 32'h5555);
        check("sh13_err", {31'h0, addr_err}, 32'h1);
        check("sh13_dmwrite", {31'h0, dm_write}, 32'h0);
        check("sh13_dmread", {31'h0, dm_read}, 32'h0);
        check("sh13_stall", {31'h0, stall}, 32'h0);
        step();
        check("errcnt_2", {24'h0, err_count}, 32'h2);
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
        check("lw400_err", {31'h0, addr_err}, 32'h1);
        check("lw400_data", load_data, 32'h0);
        step();
        check("errcnt_3", {24'h0, err_count}, 32'h3);
        drive(1'b1, 1'b0, 2'b00, 1'b1, 32'h3FF, 32'h0);
        check("lb3ff_err", {31'h0, addr_err}, 32'h0);
        check("lb3ff_dmread", {31'h0, dm_read}, 32'h1);
        step();
        check("errcnt_hold", {24'h0, err_count}, 32'h3);
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h11, 32'h0);
        repeat (260) @(posedge clk);
        #1;
        check("errcnt_sat", {24'h0, err_count}, 32'hFF);
        drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h11, 32'h0);
        step();
        check("errcnt_noreq", {24'h0, err_count}, 32'hFF);

        // reset during the write cycle of a byte RMW
        drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h14, 32'h00000011);
        check("rmw_c1_stall", {31'h0, stall}, 32'h1);
        step();
        check("rmw_c2_dmwrite", {31'h0, dm_write}, 32'h1);
        reset = 1'b1;
        #1;
        check("rst_rmw_dmwrite", {31'h0, dm_write}, 32'h0);
        check("rst_rmw_stall", {31'h0, stall}, 32'h0);
        check("rst_rmw_errcnt", {24'h0, err_count}, 32'h0);
        step();
        drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        reset = 1'b0;
        step();
        check("rst_rmw_mem", mem[5], 32'h1234EEDD);
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
        check("rst_rmw_stall_idle", {31'h0, stall}, 32'h0);
        check("rst_rmw_readback", load_data, 32'h1234EEDD);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
